// File: rtl/decoder_grant_arbiter_8.sv
// Round-robin arbiter for one resource shared by 8 requesters.
// The owner is held as a 3-bit index and decoded to one-hot grant lines.
// Hold time is bounded by MAX_HOLD when others wait, and each hand-over
// passes through one dead GAP cycle followed by an IDLE arbitration cycle.
module decoder_grant_arbiter_8 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] req_lines,
  output logic [7:0] gnt_lines,
  output logic [2:0] gnt_index,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

  state_t           state_q, state_n;
  logic [2:0]       last_q, last_n;
  logic [CNT_W-1:0] hold_q, hold_n;
  logic [7:0]       lines_n;
  logic [2:0]       index_n;
  logic             valid_n;
  logic             preempt_n;

  logic [2:0]       winner;
  logic [7:0]       owner_mask;
  logic             others_waiting;
  logic             owner_releases;
  logic             hold_expired;

  // First requester at or after last+1, wrapping 7->0; last itself is tried last.
  function automatic logic [2:0] pick_next(input logic [7:0] req, input logic [2:0] last);
    logic [2:0] cand;
    logic       found;
    pick_next = last;
    found     = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cand = last + 3'(k);
      if (!found && req[cand]) begin
        pick_next = cand;
        found     = 1'b1;
      end
    end
  endfunction

  assign winner         = pick_next(req_lines, last_q);
  assign owner_mask     = 8'(1) << gnt_index;
  assign others_waiting = |(req_lines & ~owner_mask);
  assign owner_releases = ~req_lines[gnt_index];
  assign hold_expired   = (hold_q == HOLD_MAX);

  // State and registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 3'd7;
      hold_q    <= '0;
      gnt_lines <= 8'h00;
      gnt_index <= 3'd0;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      state_q   <= state_n;
      last_q    <= last_n;
      hold_q    <= hold_n;
      gnt_lines <= lines_n;
      gnt_index <= index_n;
      gnt_valid <= valid_n;
      preempt   <= preempt_n;
    end
  end

  // Next-state selection: a release or an expired hold with competition ends a grant.
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:    if (enable && |req_lines) state_n = GRANT;
      GRANT:   if (owner_releases || (hold_expired && others_waiting)) state_n = GAP;
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next values of outputs, pointer and hold counter; the index survives idle periods.
  always_comb begin
    lines_n   = gnt_lines;
    index_n   = gnt_index;
    valid_n   = gnt_valid;
    preempt_n = 1'b0;
    last_n    = last_q;
    hold_n    = hold_q;
    unique case (state_q)
      IDLE: begin
        if (enable && |req_lines) begin
          index_n = winner;
          lines_n = 8'(1) << winner;
          valid_n = 1'b1;
          hold_n  = HOLD_ONE;
        end
      end
      GRANT: begin
        if (owner_releases) begin
          last_n  = gnt_index;
          lines_n = 8'h00;
          valid_n = 1'b0;
        end else if (hold_expired && others_waiting) begin
          last_n    = gnt_index;
          lines_n   = 8'h00;
          valid_n   = 1'b0;
          preempt_n = 1'b1;
        end else if (!hold_expired) begin
          hold_n = hold_q + HOLD_ONE;
        end
      end
      GAP: begin
        lines_n = 8'h00;
        valid_n = 1'b0;
      end
      default: begin
        lines_n = 8'h00;
        valid_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_decoder_grant_arbiter_8.sv
// Directed bench for decoder_grant_arbiter_8 (MAX_HOLD=8).
// Observed vector is {gnt_lines, gnt_index, gnt_valid, preempt}.
module tb_decoder_grant_arbiter_8;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] req_lines;
  logic [7:0] gnt_lines;
  logic [2:0] gnt_index;
  logic       gnt_valid;
  logic       preempt;

  int errors;
  int checks;

  decoder_grant_arbiter_8 #(.MAX_HOLD(8), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .req_lines (req_lines),
    .gnt_lines (gnt_lines),
    .gnt_index (gnt_index),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; req_lines = 8'h00;
    tick(); tick();
    checks++;
    if ({gnt_lines, gnt_index, gnt_valid, preempt} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", {gnt_lines, gnt_index, gnt_valid, preempt}, {8'h00, 3'd0, 1'b0, 1'b0});
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    enable = 1'b1; req_lines = 8'h01;
    tick();
    checks++;
    if ({gnt_lines, gnt_index, gnt_valid, preempt} !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL basic_grant got=%h exp=%h", {gnt_lines, gnt_index, gnt_valid, preempt}, {8'h01, 3'd0, 1'b1, 1'b0});
    end
    req_lines = 8'h00;
    tick();
    checks++;
    if ({gnt_lines, gnt_index, gnt_valid, preempt} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_gap got=%h exp=%h", {gnt_lines, gnt_index, gnt_valid, preempt}, {8'h00, 3'd0, 1'b0, 1'b0});
    end
    tick();
    checks++;
    if ({gnt_lines, gnt_valid} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL basic_idle got=%h exp=%h", {gnt_lines, gnt_valid}, {8'h00, 1'b0});
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_idx;
    logic [7:0] exp_lines;
    reset = 1'b1; tick(); reset = 1'b0;
    enable = 1'b1; req_lines = 8'hFF;
    tick();
    for (int n = 0; n < 9; n++) begin
      exp_idx   = 3'(n % 8);
      exp_lines = 8'(1) << exp_idx;
      checks++;
      if ({gnt_lines, gnt_index, gnt_valid} !== {exp_lines, exp_idx, 1'b1}) begin
        errors++;
        $display("FAIL rr_grant n=%0d got=%h exp=%h", n, {gnt_lines, gnt_index, gnt_valid}, {exp_lines, exp_idx, 1'b1});
      end
      req_lines = 8'hFF & ~exp_lines;
      tick();
      checks++;
      if ({gnt_lines, gnt_index, gnt_valid} !== {8'h00, exp_idx, 1'b0}) begin
        errors++;
        $display("FAIL rr_gap n=%0d got=%h exp=%h", n, {gnt_lines, gnt_index, gnt_valid}, {8'h00, exp_idx, 1'b0});
      end
      req_lines = 8'hFF;
      tick();
      checks++;
      if ({gnt_lines, gnt_valid} !== {8'h00, 1'b0}) begin
        errors++;
        $display("FAIL rr_idle n=%0d got=%h exp=%h", n, {gnt_lines, gnt_valid}, {8'h00, 1'b0});
      end
      tick();
    end
    req_lines = 8'h00;
    tick(); tick();
  endtask

  task automatic test_preempt();
    logic [2:0] owners [3];
    owners[0] = 3'd0; owners[1] = 3'd7; owners[2] = 3'd0;
    reset = 1'b1; tick(); reset = 1'b0;
    enable = 1'b1; req_lines = 8'h81;
    tick();
    for (int o = 0; o < 2; o++) begin
      for (int c = 1; c <= 8; c++) begin
        checks++;
        if ({gnt_lines, gnt_index, gnt_valid, preempt} !== {8'(1) << owners[o], owners[o], 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL preempt_hold o=%0d c=%0d got=%h exp=%h", o, c, {gnt_lines, gnt_index, gnt_valid, preempt},
                   {8'(1) << owners[o], owners[o], 1'b1, 1'b0});
        end
        tick();
      end
      checks++;
      if ({gnt_lines, gnt_index, gnt_valid, preempt} !== {8'h00, owners[o], 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL preempt_pulse o=%0d got=%h exp=%h", o, {gnt_lines, gnt_index, gnt_valid, preempt}, {8'h00, owners[o], 1'b0, 1'b1});
      end
      tick();
      checks++;
      if ({gnt_valid, preempt} !== 2'b00) begin
        errors++;
        $display("FAIL preempt_clear o=%0d got=%b exp=%b", o, {gnt_valid, preempt}, 2'b00);
      end
      tick();
    end
    checks++;
    if ({gnt_lines, gnt_index, gnt_valid} !== {8'h01, owners[2], 1'b1}) begin
      errors++;
      $display("FAIL preempt_return got=%h exp=%h", {gnt_lines, gnt_index, gnt_valid}, {8'h01, owners[2], 1'b1});
    end
    req_lines = 8'h00;
    tick(); tick();
  endtask

  task automatic test_saturate();
    enable = 1'b1; req_lines = 8'h04;
    tick();
    for (int c = 0; c < 20; c++) begin
      checks++;
      if ({gnt_lines, gnt_index, gnt_valid, preempt} !== {8'h04, 3'd2, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL sat_hold c=%0d got=%h exp=%h", c, {gnt_lines, gnt_index, gnt_valid, preempt}, {8'h04, 3'd2, 1'b1, 1'b0});
      end
      tick();
    end
    // counter sits at MAX_HOLD, so a newcomer forces preemption on the very next edge
    req_lines = 8'h05;
    tick();
    checks++;
    if ({gnt_lines, gnt_index, gnt_valid, preempt} !== {8'h00, 3'd2, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sat_preempt got=%h exp=%h", {gnt_lines, gnt_index, gnt_valid, preempt}, {8'h00, 3'd2, 1'b0, 1'b1});
    end
    tick(); tick();
    checks++;
    if ({gnt_lines, gnt_index, gnt_valid} !== {8'h01, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL sat_next got=%h exp=%h", {gnt_lines, gnt_index, gnt_valid}, {8'h01, 3'd0, 1'b1});
    end
    req_lines = 8'h00;
    tick(); tick();
  endtask

  task automatic test_enable();
    enable = 1'b0; req_lines = 8'h10;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({gnt_lines, gnt_valid} !== {8'h00, 1'b0}) begin
        errors++;
        $display("FAIL en_block c=%0d got=%h exp=%h", c, {gnt_lines, gnt_valid}, {8'h00, 1'b0});
      end
    end
    enable = 1'b1;
    tick();
    checks++;
    if ({gnt_lines, gnt_index, gnt_valid} !== {8'h10, 3'd4, 1'b1}) begin
      errors++;
      $display("FAIL en_grant got=%h exp=%h", {gnt_lines, gnt_index, gnt_valid}, {8'h10, 3'd4, 1'b1});
    end
    enable = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if ({gnt_lines, gnt_index, gnt_valid} !== {8'h10, 3'd4, 1'b1}) begin
        errors++;
        $display("FAIL en_persist c=%0d got=%h exp=%h", c, {gnt_lines, gnt_index, gnt_valid}, {8'h10, 3'd4, 1'b1});
      end
    end
    req_lines = 8'h00;
    tick();
    checks++;
    if ({gnt_lines, gnt_index, gnt_valid, preempt} !== {8'h00, 3'd4, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL en_release got=%h exp=%h", {gnt_lines, gnt_index, gnt_valid, preempt}, {8'h00, 3'd4, 1'b0, 1'b0});
    end
    tick();
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    enable = 1'b1; req_lines = 8'h20;
    tick();
    checks++;
    if ({gnt_lines, gnt_index, gnt_valid} !== {8'h20, 3'd5, 1'b1}) begin
      errors++;
      $display("FAIL rst_pre got=%h exp=%h", {gnt_lines, gnt_index, gnt_valid}, {8'h20, 3'd5, 1'b1});
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({gnt_lines, gnt_index, gnt_valid, preempt} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid got=%h exp=%h", {gnt_lines, gnt_index, gnt_valid, preempt}, {8'h00, 3'd0, 1'b0, 1'b0});
    end
    reset = 1'b0; req_lines = 8'h21;
    tick();
    checks++;
    if ({gnt_lines, gnt_index, gnt_valid} !== {8'h01, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL rst_restart got=%h exp=%h", {gnt_lines, gnt_index, gnt_valid}, {8'h01, 3'd0, 1'b1});
    end
    req_lines = 8'h00;
    tick(); tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1; enable = 1'b0; req_lines = 8'h00;
    test_reset();
    test_basic();
    test_round_robin();
    test_preempt();
    test_saturate();
    test_enable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
